// File: rtl/msrv32_load_wb_unit.sv
`default_nettype none
// ============================================================================
// Module  : msrv32_load_wb_unit
// Brief   : Load unit that issues a data-memory read, extracts and extends
//           the addressed byte/half/word, and writes it back to the reg file.
// Revision: 1.0 - initial release
// ============================================================================
module msrv32_load_wb_unit #(
  parameter int WIDTH          = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  msrv32_mp_clk_in,
  input  logic                  msrv32_mp_rst_in,
  input  logic                  ld_req_in,
  input  logic [2:0]            ld_funct3_in,
  input  logic [WIDTH-1:0]      ld_addr_in,
  input  logic [ADDR_WIDTH-1:0] ld_rd_addr_in,
  output logic                  busy_out,
  output logic                  dmem_req_out,
  output logic [WIDTH-1:0]      dmem_addr_out,
  input  logic                  dmem_ack_in,
  input  logic [WIDTH-1:0]      dmem_rdata_in,
  output logic [ADDR_WIDTH-1:0] rd_addr_out,
  output logic [WIDTH-1:0]      rd_out,
  output logic                  wr_en_out,
  output logic                  misaligned_out,
  output logic                  fault_out
);

  localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] c_F3_LB  = 3'b000;
  localparam logic [2:0] c_F3_LH  = 3'b001;
  localparam logic [2:0] c_F3_LW  = 3'b010;
  localparam logic [2:0] c_F3_LBU = 3'b100;
  localparam logic [2:0] c_F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [c_CNT_W-1:0]    r_wait_cnt;
  logic [2:0]            r_funct3;
  logic [1:0]            r_lane;
  logic [ADDR_WIDTH-1:0] r_rd;

  logic                  r_busy;
  logic                  r_dmem_req;
  logic [WIDTH-1:0]      r_dmem_addr;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [WIDTH-1:0]      r_rd_out;
  logic                  r_wr_en;
  logic                  r_misaligned;
  logic                  r_fault;

  logic                  w_illegal;
  logic                  w_accept;
  logic                  w_reject;
  logic                  w_ack;
  logic                  w_timeout;
  logic                  w_write;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [WIDTH-1:0]      w_ld_data;

  // Unknown funct3 encodings are treated the same as misaligned accesses.
  always_comb begin
    w_illegal = 1'b1;
    case (ld_funct3_in)
      c_F3_LB, c_F3_LBU: w_illegal = 1'b0;
      c_F3_LH, c_F3_LHU: w_illegal = ld_addr_in[0];
      c_F3_LW:           w_illegal = |ld_addr_in[1:0];
      default:           w_illegal = 1'b1;
    endcase
  end

  assign w_accept  = (r_state == ST_IDLE) && ld_req_in && !w_illegal;
  assign w_reject  = (r_state == ST_IDLE) && ld_req_in &&  w_illegal;
  assign w_ack     = (r_state == ST_REQ) && dmem_ack_in;
  assign w_timeout = (r_state == ST_REQ) && !dmem_ack_in && (r_wait_cnt == c_CNT_MAX);
  assign w_write   = w_ack && (r_rd != '0);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_REQ;
      ST_REQ: begin
        if (w_ack)          w_state_next = ST_WB;
        else if (w_timeout) w_state_next = ST_IDLE;
      end
      ST_WB:   w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge msrv32_mp_clk_in or negedge msrv32_mp_rst_in) begin
    if (!msrv32_mp_rst_in) r_state <= ST_IDLE;
    else                   r_state <= w_state_next;
  end

  // Counter is held at zero outside REQ, so every REQ entry starts from zero.
  always_ff @(posedge msrv32_mp_clk_in or negedge msrv32_mp_rst_in) begin
    if (!msrv32_mp_rst_in)       r_wait_cnt <= '0;
    else if (r_state != ST_REQ)  r_wait_cnt <= '0;
    else if (!dmem_ack_in)       r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
  end

  always_ff @(posedge msrv32_mp_clk_in or negedge msrv32_mp_rst_in) begin
    if (!msrv32_mp_rst_in) begin
      r_funct3    <= '0;
      r_lane      <= '0;
      r_rd        <= '0;
      r_dmem_addr <= '0;
    end else if (w_accept) begin
      r_funct3    <= ld_funct3_in;
      r_lane      <= ld_addr_in[1:0];
      r_rd        <= ld_rd_addr_in;
      r_dmem_addr <= {ld_addr_in[WIDTH-1:2], 2'b00};
    end
  end

  assign w_byte = dmem_rdata_in[{r_lane, 3'b000} +: 8];
  assign w_half = r_lane[1] ? dmem_rdata_in[16 +: 16] : dmem_rdata_in[0 +: 16];

  always_comb begin
    w_ld_data = dmem_rdata_in;
    case (r_funct3)
      c_F3_LB:  w_ld_data = {{(WIDTH-8){w_byte[7]}}, w_byte};
      c_F3_LH:  w_ld_data = {{(WIDTH-16){w_half[15]}}, w_half};
      c_F3_LBU: w_ld_data = {{(WIDTH-8){1'b0}}, w_byte};
      c_F3_LHU: w_ld_data = {{(WIDTH-16){1'b0}}, w_half};
      default:  w_ld_data = dmem_rdata_in;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge msrv32_mp_clk_in or negedge msrv32_mp_rst_in) begin
    if (!msrv32_mp_rst_in) begin
      r_busy       <= 1'b0;
      r_dmem_req   <= 1'b0;
      r_wr_en      <= 1'b0;
      r_misaligned <= 1'b0;
      r_fault      <= 1'b0;
      r_rd_out     <= '0;
      r_rd_addr    <= '0;
    end else begin
      r_busy       <= (w_state_next != ST_IDLE);
      r_dmem_req   <= (w_state_next == ST_REQ);
      r_wr_en      <= w_write;
      r_misaligned <= w_reject;
      r_fault      <= w_timeout;
      if (w_write) begin
        r_rd_out  <= w_ld_data;
        r_rd_addr <= r_rd;
      end
    end
  end

  assign busy_out       = r_busy;
  assign dmem_req_out   = r_dmem_req;
  assign dmem_addr_out  = r_dmem_addr;
  assign rd_addr_out    = r_rd_addr;
  assign rd_out         = r_rd_out;
  assign wr_en_out      = r_wr_en;
  assign misaligned_out = r_misaligned;
  assign fault_out      = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_msrv32_load_wb_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_msrv32_load_wb_unit
// Brief   : Directed and randomized load traffic against an arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_msrv32_load_wb_unit;

  logic        clk;
  logic        rst_n;
  logic        ld_req;
  logic [2:0]  ld_funct3;
  logic [31:0] ld_addr;
  logic [4:0]  ld_rd;
  logic        busy;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        wr_en;
  logic        misaligned;
  logic        fault;

  int          errors   = 0;
  int          checks   = 0;
  int          n_access = 0;
  int          mon_access = 0;
  logic        mon_prev = 1'b0;
  logic [31:0] mdl_rd_out  = '0;
  logic [4:0]  mdl_rd_addr = '0;

  msrv32_load_wb_unit #(.WIDTH(32), .ADDR_WIDTH(5), .TIMEOUT_CYCLES(16)) dut (
    .msrv32_mp_clk_in (clk),
    .msrv32_mp_rst_in (rst_n),
    .ld_req_in        (ld_req),
    .ld_funct3_in     (ld_funct3),
    .ld_addr_in       (ld_addr),
    .ld_rd_addr_in    (ld_rd),
    .busy_out         (busy),
    .dmem_req_out     (dmem_req),
    .dmem_addr_out    (dmem_addr),
    .dmem_ack_in      (dmem_ack),
    .dmem_rdata_in    (dmem_rdata),
    .rd_addr_out      (rd_addr),
    .rd_out           (rd_data),
    .wr_en_out        (wr_en),
    .misaligned_out   (misaligned),
    .fault_out        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts distinct memory accesses as rising edges of the request.
  always @(negedge clk) begin
    if (dmem_req && !mon_prev) mon_access <= mon_access + 1;
    mon_prev <= dmem_req;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_legal(input logic [2:0] f3, input logic [31:0] addr);
    case (f3)
      3'd0, 3'd4: return 1'b1;
      3'd1, 3'd5: return (addr % 2) == 0;
      3'd2:       return (addr % 4) == 0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_data(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    logic [31:0] b, h;
    b = (rdata >> (8 * (addr % 4))) & 32'hFF;
    h = (rdata >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128)   ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rdata;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_req"},   dmem_req, 0);
    check({tag, "_addr"},  dmem_addr, 0);
    check({tag, "_rdadr"}, rd_addr, 0);
    check({tag, "_rd"},    rd_data, 0);
    check({tag, "_wren"},  wr_en, 0);
    check({tag, "_mis"},   misaligned, 0);
    check({tag, "_fault"}, fault, 0);
  endtask

  // ack_dly: index of the REQ cycle carrying the ack (0 = first), -1 = never.
  task automatic run_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                          input logic [31:0] rdata, input int ack_dly, input bit hold);
    bit          legal;
    logic [31:0] exp_data;
    logic [31:0] waddr;
    legal    = model_legal(f3, addr);
    exp_data = model_data(f3, addr, rdata);
    waddr    = addr - (addr % 4);
    ld_req = 1'b1; ld_funct3 = f3; ld_addr = addr; ld_rd = rd;
    dmem_ack = 1'b0; dmem_rdata = $urandom;
    @(posedge clk); #1;
    if (!hold || !legal) ld_req = 1'b0;
    if (!legal) begin
      check("mis_pulse", misaligned, 1);
      check("mis_busy",  busy, 0);
      check("mis_req",   dmem_req, 0);
      check("mis_wren",  wr_en, 0);
      @(posedge clk); #1;
      check("mis_end",   misaligned, 0);
      check("mis_req2",  dmem_req, 0);
      check("mis_wren2", wr_en, 0);
      return;
    end
    n_access++;
    check("acc_busy", busy, 1);
    check("acc_req",  dmem_req, 1);
    check("acc_addr", dmem_addr, waddr);
    check("acc_mis",  misaligned, 0);
    for (int c = 0; c < 16; c++) begin
      dmem_ack   = (c == ack_dly);
      dmem_rdata = (c == ack_dly) ? rdata : $urandom;
      @(posedge clk); #1;
      dmem_ack = 1'b0; dmem_rdata = $urandom;
      if (c == ack_dly) begin
        if (rd != 0) begin
          mdl_rd_out  = exp_data;
          mdl_rd_addr = rd;
        end
        check("wb_wren",  wr_en, (rd != 0));
        check("wb_data",  rd_data, mdl_rd_out);
        check("wb_rdadr", rd_addr, mdl_rd_addr);
        check("wb_req",   dmem_req, 0);
        check("wb_busy",  busy, 1);
        check("wb_fault", fault, 0);
        break;
      end else if (c == 15) begin
        check("to_fault", fault, 1);
        check("to_busy",  busy, 0);
        check("to_req",   dmem_req, 0);
        check("to_wren",  wr_en, 0);
        check("to_data",  rd_data, mdl_rd_out);
        break;
      end else begin
        check("wait_req",   dmem_req, 1);
        check("wait_addr",  dmem_addr, waddr);
        check("wait_fault", fault, 0);
        check("wait_wren",  wr_en, 0);
      end
    end
    @(posedge clk); #1;
    check("end_wren",  wr_en, 0);
    check("end_busy",  busy, 0);
    check("end_fault", fault, 0);
    check("end_req",   dmem_req, 0);
    check("end_data",  rd_data, mdl_rd_out);
    check("end_rdadr", rd_addr, mdl_rd_addr);
  endtask

  initial begin
    int          ack;
    bit          hold;
    logic [2:0]  f3;
    logic [31:0] addr;
    rst_n = 1'b0; ld_req = 1'b0; ld_funct3 = '0; ld_addr = '0; ld_rd = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    @(negedge clk) rst_n = 1'b1;

    // Request on the first edge after reset release.
    run_load(3'b000, 32'h0000_1003, 5'd1, 32'h80FF_1234, 2, 1'b0);
    check("lb_const", rd_data, 32'hFFFF_FF80);
    run_load(3'b101, 32'h0000_2002, 5'd2, 32'hBEEF_0001, 0, 1'b0);
    check("lhu_const", rd_data, 32'h0000_BEEF);
    run_load(3'b001, 32'h0000_2002, 5'd3, 32'hBEEF_0001, 0, 1'b0);
    check("lh_const", rd_data, 32'hFFFF_BEEF);
    run_load(3'b010, 32'h0000_3001, 5'd4, 32'h1111_2222, 0, 1'b0);
    run_load(3'b111, 32'h0000_3000, 5'd4, 32'h1111_2222, 0, 1'b0);
    run_load(3'b010, 32'h0000_4000, 5'd5, 32'h5555_AAAA, -1, 1'b0);
    run_load(3'b010, 32'h0000_4000, 5'd6, 32'h1234_5678, 15, 1'b0);
    check("lw_last", rd_data, 32'h1234_5678);
    run_load(3'b010, 32'h0000_5000, 5'd0, 32'hDEAD_BEEF, 1, 1'b0);

    // Reset asserted in the middle of REQ.
    ld_req = 1'b1; ld_funct3 = 3'b010; ld_addr = 32'h0000_6000; ld_rd = 5'd7;
    @(posedge clk); #1;
    ld_req = 1'b0;
    n_access++;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("arst");
    mdl_rd_out = '0; mdl_rd_addr = '0;
    @(posedge clk); #1;
    check_all_zero("arst_hold");
    @(negedge clk) rst_n = 1'b1;
    run_load(3'b100, 32'h0000_7001, 5'd8, 32'h00C3_7F00, 0, 1'b0);

    // Request held high through busy periods, then back-to-back.
    run_load(3'b010, 32'h0000_8000, 5'd9,  32'hCAFE_F00D, 3, 1'b1);
    run_load(3'b010, 32'h0000_8004, 5'd10, 32'h0BAD_BEEF, 0, 1'b1);
    run_load(3'b000, 32'h0000_8002, 5'd11, 32'h0080_0000, 1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom;
      ack  = $urandom_range(0, 9);
      if (ack == 6)     ack = 15;
      else if (ack == 7) ack = -1;
      else if (ack > 7)  ack = 0;
      hold = (ack >= 0) && ($urandom_range(0, 3) == 0);
      run_load(f3, addr, 5'($urandom_range(0, 31)), $urandom, ack, hold);
    end
    ld_req = 1'b0;
    @(posedge clk); #1;
    check("idle_final", busy, 0);
    check("access_count", mon_access, n_access);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
